// File: rtl/aes_ctrl.sv
// aes_ctrl: round sequencer for an iterative AES-128 core.
//
// Holds the cipher key and direction for the key expander. For each block it
// walks the cipher datapath through rounds 0..10. Each round fetches a round
// key from the expander and then launches the round on the datapath.
//
// Ports
//   clk, rst        single clock; synchronous active-high reset
//   key_vld/key_rdy key handshake; key and enc are captured on it
//   key[127:0], enc cipher key and direction (1 encrypt, 0 decrypt)
//   blk_req         level request to process one block
//   blk_ack         one-cycle pulse when blk_req is accepted
//   blk_busy        high whenever the sequencer is not idle
//   blk_done        one-cycle pulse when all 11 rounds have finished
//   kx_key_ld_p     load pulse to the key expander
//   kx_key, kx_enc  stored key and direction to the key expander
//   kx_rk_vld/kx_rk_rdy, kx_rk[127:0]
//                   round-key handshake from the key expander
//   rnd_go          one-cycle pulse that starts a round on the datapath
//   rnd_idx[3:0]    current round index 0..10
//   rnd_key[127:0]  registered round key for the current round
//   rnd_first       round 0 (initial AddRoundKey only)
//   rnd_last        round 10 (final round, no MixColumns)
//   rnd_done        datapath finished the current round
module aes_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_vld,
   output logic         key_rdy,
   input  logic [127:0] key,
   input  logic         enc,
   input  logic         blk_req,
   output logic         blk_ack,
   output logic         blk_busy,
   output logic         blk_done,
   output logic         kx_key_ld_p,
   output logic [127:0] kx_key,
   output logic         kx_enc,
   input  logic         kx_rk_vld,
   input  logic [127:0] kx_rk,
   output logic         kx_rk_rdy,
   output logic         rnd_go,
   output logic [3:0]   rnd_idx,
   output logic [127:0] rnd_key,
   output logic         rnd_first,
   output logic         rnd_last,
   input  logic         rnd_done
);

   localparam logic [3:0] LAST_RND = 4'd10;

   typedef enum logic [2:0] {IDLE, KLD, WAIT_RK, RUN, DONE} state_t;

   state_t state, state_nxt;
   logic   key_loaded;
   logic   go_p1;     // set for the first RUN cycle of a round
   logic   key_hs;
   logic   blk_acc;
   logic   rk_hs;
   logic   rnd_end;

   always_comb begin
      state_nxt   = state;
      key_rdy     = 1'b0;
      blk_ack     = 1'b0;
      kx_key_ld_p = 1'b0;
      kx_rk_rdy   = 1'b0;
      blk_done    = 1'b0;
      key_hs      = 1'b0;
      blk_acc     = 1'b0;
      rk_hs       = 1'b0;
      rnd_end     = 1'b0;
      case (state)
         IDLE: begin
            key_rdy = 1'b1;
            key_hs  = key_vld;
            // A key offered in the same cycle takes priority over the
            // block request. The request stays pending until a later cycle.
            blk_acc = blk_req && key_loaded && !key_vld;
            blk_ack = blk_acc;
            if (blk_acc) state_nxt = KLD;
         end
         KLD: begin
            kx_key_ld_p = 1'b1;
            state_nxt   = WAIT_RK;
         end
         WAIT_RK: begin
            kx_rk_rdy = 1'b1;
            rk_hs     = kx_rk_vld;
            if (rk_hs) state_nxt = RUN;
         end
         RUN: begin
            // rnd_done belongs to the round just launched. It is only
            // trusted after the go cycle.
            rnd_end = rnd_done && !go_p1;
            if (rnd_end) state_nxt = (rnd_idx == LAST_RND) ? DONE : WAIT_RK;
         end
         DONE: begin
            blk_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Under reset every pulse and handshake is suppressed. This includes a
      // reset that lands in the middle of a block.
      if (rst) begin
         blk_ack     = 1'b0;
         kx_key_ld_p = 1'b0;
         kx_rk_rdy   = 1'b0;
         blk_done    = 1'b0;
         key_hs      = 1'b0;
         blk_acc     = 1'b0;
         rk_hs       = 1'b0;
         rnd_end     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         key_loaded <= 1'b0;
         go_p1      <= 1'b0;
         rnd_idx    <= 4'd0;
         rnd_key    <= '0;
         kx_key     <= '0;
         kx_enc     <= 1'b0;
      end else begin
         state <= state_nxt;
         go_p1 <= rk_hs;
         if (key_hs) begin
            kx_key     <= key;
            kx_enc     <= enc;
            key_loaded <= 1'b1;
         end
         if (blk_acc) begin
            rnd_idx <= 4'd0;
         end else if (rnd_end && rnd_idx != LAST_RND) begin
            rnd_idx <= rnd_idx + 4'd1;
         end
         if (rk_hs) rnd_key <= kx_rk;
      end
   end

   assign rnd_go    = go_p1 && !rst;
   assign blk_busy  = (state != IDLE);
   assign rnd_first = (rnd_idx == 4'd0);
   assign rnd_last  = (rnd_idx == LAST_RND);

endmodule

// File: tb/tb_aes_ctrl.sv
// Testbench for aes_ctrl. Directed steps drive zero-wait and stalled
// responders. Expected round keys and indices go into a scoreboard when a
// round key is handed over, and are checked when rnd_go fires.
module tb_aes_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_vld;
   logic         key_rdy;
   logic [127:0] key;
   logic         enc;
   logic         blk_req;
   logic         blk_ack;
   logic         blk_busy;
   logic         blk_done;
   logic         kx_key_ld_p;
   logic [127:0] kx_key;
   logic         kx_enc;
   logic         kx_rk_vld;
   logic [127:0] kx_rk;
   logic         kx_rk_rdy;
   logic         rnd_go;
   logic [3:0]   rnd_idx;
   logic [127:0] rnd_key;
   logic         rnd_first;
   logic         rnd_last;
   logic         rnd_done;

   aes_ctrl dut (
      .clk(clk), .rst(rst),
      .key_vld(key_vld), .key_rdy(key_rdy), .key(key), .enc(enc),
      .blk_req(blk_req), .blk_ack(blk_ack), .blk_busy(blk_busy), .blk_done(blk_done),
      .kx_key_ld_p(kx_key_ld_p), .kx_key(kx_key), .kx_enc(kx_enc),
      .kx_rk_vld(kx_rk_vld), .kx_rk(kx_rk), .kx_rk_rdy(kx_rk_rdy),
      .rnd_go(rnd_go), .rnd_idx(rnd_idx), .rnd_key(rnd_key),
      .rnd_first(rnd_first), .rnd_last(rnd_last), .rnd_done(rnd_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           idx;
      logic [127:0] key;
   } exp_t;

   exp_t         sb[$];
   int           total = 0;
   int           bad = 0;
   logic [127:0] exp_key = '0;
   logic         exp_enc = 1'b0;
   logic [127:0] last_rk = '0;

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K3 = 128'hfedcba98765432100123456789abcdef;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rst_pulses(input string tag);
      chk({tag, "_ack"}, blk_ack, 0);
      chk({tag, "_ld"}, kx_key_ld_p, 0);
      chk({tag, "_rkrdy"}, kx_rk_rdy, 0);
      chk({tag, "_go"}, rnd_go, 0);
      chk({tag, "_done"}, blk_done, 0);
   endtask

   task automatic idle_cycles(input int n, input bit req);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         blk_req = req; key_vld = 1'b0; kx_rk_vld = 1'b0; rnd_done = 1'b0;
         #1;
         chk("idle_no_ack", blk_ack, 0);
         chk("idle_no_ld", kx_key_ld_p, 0);
         chk("idle_busy", blk_busy, 0);
      end
   endtask

   // Offers a key for one cycle. key_vld is dropped by the next step.
   task automatic load_key(input logic [127:0] k, input bit e, input bit req);
      @(negedge clk);
      key_vld = 1'b1; key = k; enc = e; blk_req = req;
      #1;
      chk("load_key_rdy", key_rdy, 1);
      chk("load_no_ack", blk_ack, 0);
      exp_key = k;
      exp_enc = e;
   endtask

   task automatic run_block(input bit stall, input bit junk, input bit key_during,
                            input int abort_idx, input bit check_lat);
      int   acks = 0, lds = 0, gos = 0, ack_cyc = -1, done_cyc = -1;
      int   rk_cnt = -1, dn_cnt = 0, hs_idx = 0;
      bit   done_seen = 0, aborted = 0, in_run = 0;
      exp_t e;
      sb.delete();
      for (int cyc = 0; cyc < 1000 && !done_seen && !aborted; cyc++) begin
         @(negedge clk);
         blk_req = (acks == 0);
         key_vld = key_during && blk_busy;
         key     = ~exp_key;
         enc     = ~exp_enc;
         // datapath responder
         if (in_run) begin
            if (rnd_go) dn_cnt = stall ? int'($urandom_range(1, 8)) - 1 : 0;
            if (dn_cnt == 0) begin
               rnd_done = 1'b1;
               if (!rnd_go) in_run = 0;
            end else begin
               rnd_done = 1'b0;
               dn_cnt--;
            end
         end else begin
            rnd_done = junk ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         // key expander responder
         if (kx_rk_rdy) begin
            if (rk_cnt < 0) rk_cnt = stall ? int'($urandom_range(0, 5)) : 0;
            if (rk_cnt == 0) begin
               kx_rk_vld = 1'b1;
               kx_rk = {$urandom, $urandom, $urandom, $urandom};
               e.idx = hs_idx;
               e.key = kx_rk;
               sb.push_back(e);
               hs_idx++;
               rk_cnt = -1;
               in_run = 1;
            end else begin
               kx_rk_vld = 1'b0;
               rk_cnt--;
            end
         end else begin
            kx_rk_vld = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            kx_rk = {$urandom, $urandom, $urandom, $urandom};
         end
         if (abort_idx >= 0 && rnd_go && hs_idx - 1 == abort_idx) begin
            rst = 1'b1;
            aborted = 1;
         end
         #1;
         if (aborted) begin
            chk_rst_pulses("midrst");
         end else begin
            if (cyc == 0) chk("kx_key_at_start", kx_key, exp_key);
            if (blk_ack) begin acks++; ack_cyc = cyc; end
            if (kx_key_ld_p) begin
               lds++;
               chk("ld_after_ack", cyc, ack_cyc + 1);
            end
            if (rnd_go) begin
               gos++;
               chk("sb_empty_at_go", sb.size() == 0, 0);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  last_rk = e.key;
                  chk("go_idx", rnd_idx, e.idx);
                  chk("go_key", rnd_key, e.key);
                  chk("go_first", rnd_first, e.idx == 0);
                  chk("go_last", rnd_last, e.idx == 10);
               end
            end else if (gos > 0 && blk_busy && !kx_rk_rdy) begin
               chk("rnd_key_hold", rnd_key, last_rk);
            end
            if (blk_busy) begin
               chk("key_rdy_busy", key_rdy, 0);
               if (key_during) chk("kx_key_busy", kx_key, exp_key);
            end
            if (blk_done) begin done_seen = 1; done_cyc = cyc; end
         end
      end
      if (abort_idx >= 0) begin
         chk("abort_hit", aborted, 1);
         @(negedge clk);
         rst = 1'b0; blk_req = 1'b0; key_vld = 1'b0; kx_rk_vld = 1'b0; rnd_done = 1'b0;
         #1;
         chk("postrst_busy", blk_busy, 0);
         chk("postrst_key_rdy", key_rdy, 1);
         chk("postrst_idx", rnd_idx, 0);
         chk("postrst_rnd_key", rnd_key, 0);
         chk("postrst_kx_key", kx_key, 0);
         chk("postrst_kx_enc", kx_enc, 0);
         return;
      end
      chk("done_seen", done_seen, 1);
      chk("go_count", gos, 11);
      chk("ack_count", acks, 1);
      chk("ack_cycle", ack_cyc, 0);
      chk("ld_count", lds, 1);
      chk("sb_left", sb.size(), 0);
      chk("done_idx", rnd_idx, 10);
      chk("done_kx_key", kx_key, exp_key);
      chk("done_kx_enc", kx_enc, exp_enc);
      // cycles strictly between blk_ack and blk_done: KLD plus 11 x 3
      if (check_lat) chk("latency", done_cyc - ack_cyc - 1, 34);
      @(negedge clk);
      blk_req = 1'b0; key_vld = 1'b0; kx_rk_vld = 1'b0; rnd_done = 1'b0;
      #1;
      chk("post_done_pulse", blk_done, 0);
      chk("post_busy", blk_busy, 0);
      chk("post_key_rdy", key_rdy, 1);
      chk("post_idx_hold", rnd_idx, 10);
      chk("post_rnd_key", rnd_key, last_rk);
      chk("post_kx_key", kx_key, exp_key);
   endtask

   initial begin
      rst = 1'b1; key_vld = 1'b0; key = '0; enc = 1'b0; blk_req = 1'b0;
      kx_rk_vld = 1'b0; kx_rk = '0; rnd_done = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk_rst_pulses("por");
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_key_rdy", key_rdy, 1);
      chk("rst_busy", blk_busy, 0);
      chk("rst_idx", rnd_idx, 0);
      chk("rst_rnd_key", rnd_key, 0);
      chk("rst_kx_key", kx_key, 0);
      chk("rst_kx_enc", kx_enc, 0);
      chk("rst_first", rnd_first, 1);

      // request without a key is ignored; acked on the IDLE cycle after load
      idle_cycles(4, 1'b1);
      load_key(K1, 1'b1, 1'b1);
      run_block(1'b0, 1'b0, 1'b0, -1, 1'b1);

      // random stalls with stray valids outside their windows
      run_block(1'b1, 1'b1, 1'b0, -1, 1'b0);
      run_block(1'b1, 1'b1, 1'b0, -1, 1'b0);

      // key and request together: key wins, ack follows
      load_key(K2, 1'b0, 1'b1);
      run_block(1'b0, 1'b0, 1'b0, -1, 1'b1);

      // key offered while busy must not disturb the stored key
      run_block(1'b0, 1'b0, 1'b1, -1, 1'b1);

      // reset in the middle of round 5
      run_block(1'b0, 1'b0, 1'b0, 5, 1'b0);
      idle_cycles(4, 1'b1);
      load_key(K3, 1'b1, 1'b1);
      run_block(1'b1, 1'b0, 1'b0, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
